shift_left_2: RTL and testbench

- Registered shift-left-by-2 unit for the MIPS datapath.
- Converts word offsets, such as the sign-extended branch immediate or the jump index, into byte offsets before the PC adder.
- Implemented as a single pipeline stage with a valid/ready handshake.
- Also flags when non-zero bits are shifted out of the top.

---
 rtl/mips_pkg.sv | 9 +
 rtl/pipe_stage.sv | 44 ++++
 rtl/shift_left_2.sv | 42 ++++
 tb/tb_shift_left_2.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
package mips_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int BRANCH_SHIFT = 2;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/pipe_stage.sv
// Generic single-entry valid/ready register slice; full throughput, no bubble.
module pipe_stage #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  always_comb begin
    in_ready = !vld_q || out_ready;
    data_d   = data_q;
    vld_d    = vld_q;
    // A fresh accept wins over a consume, so the slot refills on the same edge.
    if (in_valid && in_ready) begin
      data_d = in_data;
      vld_d  = 1'b1;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;

endmodule

// File: rtl/shift_left_2.sv
// Registered logical shift-left (word to byte offset) with shifted-out-bit flag.
module shift_left_2
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int SHIFT = BRANCH_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  logic [WIDTH-1:0] shifted;
  logic             ovf;
  logic [WIDTH:0]   stage_out;

  always_comb begin
    shifted = {in[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
    ovf     = |in[WIDTH-1:WIDTH-SHIFT];
  end

  pipe_stage #(.WIDTH(WIDTH + 1)) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({ovf, shifted}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (stage_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out      = stage_out[WIDTH-1:0];
  assign overflow = stage_out[WIDTH];

endmodule

// File: tb/tb_shift_left_2.sv
// Scoreboard bench for shift_left_2: directed cases plus random traffic.
module tb_shift_left_2;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  word_t       in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  word_t       out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  logic [32:0] sbq[$];
  logic [32:0] mon_exp;

  shift_left_2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: multiply by 4 in 64-bit arithmetic; anything above bit 31 overflowed.
  function automatic logic [32:0] model(input word_t d);
    logic [63:0] p;
    p = 64'(d) * 64'd4;
    return {(p[63:32] != 64'd0), p[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, log any accept, return #1 after the rising edge.
  task automatic cyc(input word_t d, input logic iv, input logic ordy, input logic rs);
    @(negedge clk);
    rst_n = rs; in = d; in_valid = iv; out_ready = ordy;
    #1;
    if (!rs) sbq.delete();
    else if (iv && in_ready) sbq.push_back(model(d));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got %h expected none", {overflow, out});
      end else begin
        mon_exp = sbq.pop_front();
        chk("sb_result", {overflow, out}, mon_exp);
      end
    end
  end

  initial begin
    word_t vec[6] = '{32'h0, 32'h1, 32'h10, 32'hFFFFFFFF, 32'h3FFFFFFF, 32'h40000000};
    word_t ex[6]  = '{32'h0, 32'h4, 32'h40, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0};
    logic  eo[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) cyc(32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    chk("rst_state", {31'b0, out_valid, overflow, out}, 33'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", {32'b0, in_ready}, 33'd1);
    chk("rst_no_valid", {32'b0, out_valid}, 33'd0);

    for (int i = 0; i < 6; i++) begin
      cyc(vec[i], 1'b1, 1'b1, 1'b1);
      chk("basic_valid", {32'b0, out_valid}, 33'd1);
      chk("basic_value", {overflow, out}, {eo[i], ex[i]});
    end
    cyc('0, 1'b0, 1'b1, 1'b1);
    chk("idle_drop_valid", {32'b0, out_valid}, 33'd0);

    cyc(32'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(32'd7, 1'b1, 1'b0, 1'b1);
      chk("stall_out", {out_valid, out}, {1'b1, 32'd20});
      chk("stall_in_ready", {32'b0, in_ready}, 33'd0);
    end
    cyc(32'd7, 1'b1, 1'b1, 1'b1);
    chk("bp_refill", {out_valid, out}, {1'b1, 32'd28});
    cyc('0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      cyc($urandom, 1'b1, 1'b1, 1'b1);
      chk("thru_valid", {32'b0, out_valid}, 33'd1);
    end
    cyc('0, 1'b0, 1'b1, 1'b1);

    cyc(32'h4, 1'b1, 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b1);
    chk("held_before_rst", {out_valid, out}, {1'b1, 32'h10});
    cyc('0, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_valid", {32'b0, out_valid}, 33'd0);
    cyc('0, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_stays_empty", {32'b0, out_valid}, 33'd0);

    for (int i = 0; i < 1000; i++)
      cyc($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b1);
    for (int i = 0; i < 3; i++) cyc('0, 1'b0, 1'b1, 1'b1);
    chk("sb_drained", 33'(sbq.size()), 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
